// File: rtl/clkgen_pkg.sv
// Shared types and defaults for the clock-generator reset/lock sequencer.
// Holds the sequencer state encoding and the helpers used to size its counters.
package clkgen_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam int unsigned DEF_PLL_RST_CYCLES      = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_STAGGER_CYCLES      = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 50000;
  localparam int unsigned DEF_RETRY_W             = 4;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // A counter that stops at n-1 needs clog2(n) bits; never fewer than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkgen_reset_sequencer_if.sv
// Signal bundle between the reset sequencer and the PLL / downstream reset consumers.
// master = sequencer side, slave = PLL and reset-consumer side.
interface clkgen_reset_sequencer_if #(
  parameter int unsigned RETRY_W = 4
);
  import clkgen_pkg::*;

  // No valid/ready handshake here: every signal is a level. locked is asynchronous
  // to refclk and is only ever consumed through a synchronizer; every other signal
  // is a registered output of the sequencer, stable between refclk rising edges.
  logic               locked;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               sdram_rst_n;
  logic               ready;
  logic [RETRY_W-1:0] retry_cnt;
  state_t             state;

  modport master (
    input  locked,
    output pll_rst, sys_rst_n, sdram_rst_n, ready, retry_cnt, state
  );

  modport slave (
    output locked,
    input  pll_rst, sys_rst_n, sdram_rst_n, ready, retry_cnt, state
  );

endinterface

// File: rtl/clkgen_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear, for single
// level signals crossing into the local clock domain.
module clkgen_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clkgen_reset_sequencer.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for stable lock, then
// releases system and SDRAM resets in order. Optional lock-timeout retry: CLKGEN_LOCK_RETRY_EN.
module clkgen_reset_sequencer
  import clkgen_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned STAGGER_CYCLES      = DEF_STAGGER_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned RETRY_W             = DEF_RETRY_W
) (
  input  logic                             refclk,
  input  logic                             rst_n,
  clkgen_reset_sequencer_if.master         bus
);

  localparam int unsigned CNT_W =
    cnt_width(max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, STAGGER_CYCLES));
  localparam logic [CNT_W-1:0] PLL_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);

  if (PLL_RST_CYCLES < 2) begin : g_bad_pll_rst
    $error("PLL_RST_CYCLES must be at least 2");
  end
  if (LOCK_STABLE_CYCLES < 1 || STAGGER_CYCLES < 1 || LOCK_TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("LOCK_STABLE_CYCLES, STAGGER_CYCLES and LOCK_TIMEOUT_CYCLES must be at least 1");
  end
  if (RETRY_W < 1) begin : g_bad_retry_w
    $error("RETRY_W must be at least 1");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;
  logic             lock_lost;
  logic             in_rel_run;
  logic             pll_rst_q;
  logic             sys_rst_q;
  logic             sdram_rst_q;
  logic             ready_q;

`ifdef CLKGEN_LOCK_RETRY_EN
  localparam int unsigned TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]   tmo_cnt;
  logic [RETRY_W-1:0] retry_q;
`endif

  clkgen_sync2 u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (bus.locked),
    .q     (lock_s)
  );

  assign in_rel_run = (state == RELEASE) || (state == RUN);

  // Lock loss after release is registered once before acting on it, so the
  // downstream resets always come from a fully registered decision.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      cnt         <= '0;
      lock_lost   <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b0;
      sdram_rst_q <= 1'b0;
      ready_q     <= 1'b0;
`ifdef CLKGEN_LOCK_RETRY_EN
      tmo_cnt     <= '0;
      retry_q     <= '0;
`endif
    end else begin
      lock_lost <= in_rel_run && !lock_s;
      if (in_rel_run && lock_lost) begin
        state       <= PLL_RST;
        cnt         <= '0;
        pll_rst_q   <= 1'b1;
        sys_rst_q   <= 1'b0;
        sdram_rst_q <= 1'b0;
        ready_q     <= 1'b0;
      end else begin
        case (state)
          PLL_RST: begin
            if (cnt == PLL_LAST) begin
              state     <= WAIT_LOCK;
              cnt       <= '0;
              pll_rst_q <= 1'b0;
`ifdef CLKGEN_LOCK_RETRY_EN
              tmo_cnt   <= '0;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_LOCK: begin
            if (lock_s) begin
              state <= STABLE;
              cnt   <= '0;
            end
`ifdef CLKGEN_LOCK_RETRY_EN
            else if (tmo_cnt == TMO_LAST) begin
              state     <= PLL_RST;
              cnt       <= '0;
              tmo_cnt   <= '0;
              pll_rst_q <= 1'b1;
              if (retry_q != '1) retry_q <= retry_q + 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
`endif
          end
          STABLE: begin
            if (!lock_s) begin
              state   <= WAIT_LOCK;
              cnt     <= '0;
`ifdef CLKGEN_LOCK_RETRY_EN
              tmo_cnt <= '0;
`endif
            end else if (cnt == STABLE_LAST) begin
              state     <= RELEASE;
              cnt       <= '0;
              sys_rst_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == STAGGER_LAST) begin
              state       <= RUN;
              cnt         <= '0;
              sdram_rst_q <= 1'b1;
              ready_q     <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RUN: begin
            cnt <= '0;
          end
          default: begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b0;
            sdram_rst_q <= 1'b0;
            ready_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rst_n   = sys_rst_q;
  assign bus.sdram_rst_n = sdram_rst_q;
  assign bus.ready       = ready_q;
  assign bus.state       = state;
`ifdef CLKGEN_LOCK_RETRY_EN
  assign bus.retry_cnt   = retry_q;
`else
  assign bus.retry_cnt   = '0;
`endif

endmodule

// File: tb/tb_clkgen_reset_sequencer.sv
// Bench for clkgen_reset_sequencer: directed scenarios plus randomized lock waveforms,
// checked against an edge-timestamp reference model. Honours CLKGEN_LOCK_RETRY_EN.
module tb_clkgen_reset_sequencer;
  import clkgen_pkg::*;

  localparam int P   = 4;
  localparam int LSC = 8;
  localparam int S   = 3;
  localparam int LTC = 20;
  localparam int RW  = 4;
  localparam int RETRY_MAX = (1 << RW) - 1;

  typedef logic [RW+3:0] vec_t;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;

  clkgen_reset_sequencer_if #(.RETRY_W(RW)) bus ();

  clkgen_reset_sequencer #(
    .PLL_RST_CYCLES      (P),
    .LOCK_STABLE_CYCLES  (LSC),
    .STAGGER_CYCLES      (S),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .RETRY_W             (RW)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  always #10 refclk = ~refclk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model + scoreboard ----------------
  // Edge k = k-th rising edge since rst_n released. The sequencer sees the lock
  // sample taken two edges earlier. Expected outputs follow from timestamps:
  // PLL reset high for P edges from sequence start t0, release after LSC+1
  // consecutive lock-seen edges, ready S edges later, loss acted on one edge
  // after it is seen post-release, timeout LTC edges after waiting began.
  vec_t exp_q[$];
  int   edge_k;
  bit   lk [0:1023];
  int   t0, wait_start, run, rel, pending, retry_m;

  always @(posedge refclk or negedge rst_n) begin
    bit ls;
    bit pll_e, sys_e, rdy_e;
    if (!rst_n) begin
      edge_k = 0; t0 = 0; wait_start = 0; run = 0; rel = -1; pending = -1; retry_m = 0;
      exp_q.delete();
    end else begin
      edge_k++;
      if (edge_k <= 1023) lk[edge_k] = bus.locked;
      ls = (edge_k >= 3 && edge_k <= 1025) ? lk[edge_k-2] : 1'b0;
      if (pending == edge_k) begin
        t0 = edge_k; rel = -1; run = 0; pending = -1;
      end else if (edge_k < t0 + P) begin
        // PLL reset pulse in progress
      end else if (edge_k == t0 + P) begin
        wait_start = edge_k; run = 0;
      end else if (rel < 0) begin
        if (ls) begin
          run++;
          if (run == LSC + 1) rel = edge_k;
        end else if (run > 0) begin
          run = 0; wait_start = edge_k;
        end
`ifdef CLKGEN_LOCK_RETRY_EN
        else if (edge_k - wait_start == LTC) begin
          t0 = edge_k;
          if (retry_m < RETRY_MAX) retry_m++;
        end
`endif
      end else if (!ls && pending < 0) begin
        pending = edge_k + 1;
      end
      pll_e = (edge_k < t0 + P);
      sys_e = (rel >= 0);
      rdy_e = (rel >= 0) && (edge_k >= rel + S);
      exp_q.push_back({pll_e, sys_e, rdy_e, rdy_e, RW'(retry_m)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge refclk);
    rst_n = 1'b0;
    bus.locked = 1'b0;
    repeat (2) @(negedge refclk);
    rst_n = 1'b1;
  endtask

  task automatic tick(output vec_t exp, output vec_t got);
    @(posedge refclk);
    #1;
    got = {bus.pll_rst, bus.sys_rst_n, bus.sdram_rst_n, bus.ready, bus.retry_cnt};
    if (exp_q.size() == 0) exp = 'x;
    else exp = exp_q.pop_front();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vec_t got;
    bus.locked = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge refclk);
    got = {bus.pll_rst, bus.sys_rst_n, bus.sdram_rst_n, bus.ready, bus.retry_cnt};
    n_checks++;
    if (got !== {4'b1000, RW'(0)}) begin
      n_fail++; $display("FAIL reset_values got=%b exp=%b", got, {4'b1000, RW'(0)});
    end
    n_checks++;
    if (bus.state !== PLL_RST) begin
      n_fail++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, PLL_RST);
    end
  endtask

  task automatic test_pll_release();
    vec_t e, g;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      tick(e, g);
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL pll_release edge=%0d got=%b exp=%b", edge_k, g, e); end
      if (edge_k == 3) begin
        n_checks++;
        if (bus.pll_rst !== 1'b1) begin n_fail++; $display("FAIL pll_rst_edge3 got=%b exp=1", bus.pll_rst); end
      end
      if (edge_k == 4) begin
        n_checks++;
        if (bus.pll_rst !== 1'b0) begin n_fail++; $display("FAIL pll_rst_edge4 got=%b exp=0", bus.pll_rst); end
      end
    end
    n_checks++;
    if ({bus.sys_rst_n, bus.sdram_rst_n, bus.ready} !== 3'b000) begin
      n_fail++; $display("FAIL no_lock_held got=%b exp=000", {bus.sys_rst_n, bus.sdram_rst_n, bus.ready});
    end
  endtask

  task automatic test_lock_sequence();
    vec_t e, g;
    apply_reset();
    for (int i = 0; i < 26; i++) begin
      tick(e, g);
      if (edge_k == 9) bus.locked = 1'b1;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL lock_seq edge=%0d got=%b exp=%b", edge_k, g, e); end
      if (edge_k == 19 || edge_k == 20) begin
        n_checks++;
        if (bus.sys_rst_n !== (edge_k == 20)) begin
          n_fail++; $display("FAIL sys_release edge=%0d got=%b exp=%b", edge_k, bus.sys_rst_n, edge_k == 20);
        end
      end
      if (edge_k == 22 || edge_k == 23) begin
        n_checks++;
        if ({bus.sdram_rst_n, bus.ready} !== {2{edge_k == 23}}) begin
          n_fail++; $display("FAIL ready_release edge=%0d got=%b exp=%b", edge_k, {bus.sdram_rst_n, bus.ready}, {2{edge_k == 23}});
        end
      end
    end
  endtask

  // Continues from test_lock_sequence, which leaves the sequencer in RUN.
  task automatic test_lock_loss();
    vec_t e, g;
    for (int i = 0; i < 40; i++) begin
      tick(e, g);
      if (edge_k == 39) bus.locked = 1'b0;
      if (edge_k == 43) bus.locked = 1'b1;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL lock_loss edge=%0d got=%b exp=%b", edge_k, g, e); end
      if (edge_k == 42) begin
        n_checks++;
        if (g[RW+3:RW] !== 4'b0111) begin n_fail++; $display("FAIL loss_edge42 got=%b exp=0111", g[RW+3:RW]); end
      end
      if (edge_k == 43) begin
        n_checks++;
        if (g[RW+3:RW] !== 4'b1000) begin n_fail++; $display("FAIL loss_edge43 got=%b exp=1000", g[RW+3:RW]); end
      end
      if (edge_k == 58 || edge_k == 59) begin
        n_checks++;
        if (bus.ready !== (edge_k == 59)) begin
          n_fail++; $display("FAIL relock_ready edge=%0d got=%b exp=%b", edge_k, bus.ready, edge_k == 59);
        end
      end
    end
  endtask

  task automatic test_dropout();
    vec_t e, g;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      tick(e, g);
      if (edge_k == 9)  bus.locked = 1'b1;
      if (edge_k == 13) bus.locked = 1'b0;
      if (edge_k == 14) bus.locked = 1'b1;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL dropout edge=%0d got=%b exp=%b", edge_k, g, e); end
      if (edge_k == 20 || edge_k == 24 || edge_k == 25) begin
        n_checks++;
        if (bus.sys_rst_n !== (edge_k == 25)) begin
          n_fail++; $display("FAIL dropout_sys edge=%0d got=%b exp=%b", edge_k, bus.sys_rst_n, edge_k == 25);
        end
      end
      if (edge_k == 28) begin
        n_checks++;
        if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL dropout_ready got=%b exp=1", bus.ready); end
      end
    end
  endtask

  task automatic test_retry();
    vec_t e, g;
    apply_reset();
    for (int i = 0; i < 24 * 16 + 8; i++) begin
      tick(e, g);
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL retry edge=%0d got=%b exp=%b", edge_k, g, e); end
`ifdef CLKGEN_LOCK_RETRY_EN
      if (edge_k == 23 || edge_k == 24 || edge_k == 48) begin
        n_checks++;
        if ({bus.pll_rst, bus.retry_cnt} !== {edge_k != 23, RW'(edge_k / 24)}) begin
          n_fail++; $display("FAIL retry_pulse edge=%0d got=%b exp=%b", edge_k, {bus.pll_rst, bus.retry_cnt}, {edge_k != 23, RW'(edge_k / 24)});
        end
      end
    end
    n_checks++;
    if (bus.retry_cnt !== RW'(RETRY_MAX)) begin
      n_fail++; $display("FAIL retry_saturate got=%0d exp=%0d", bus.retry_cnt, RETRY_MAX);
    end
`else
    end
    n_checks++;
    if ({bus.pll_rst, bus.retry_cnt} !== {1'b0, RW'(0)}) begin
      n_fail++; $display("FAIL no_retry got=%b exp=%b", {bus.pll_rst, bus.retry_cnt}, {1'b0, RW'(0)});
    end
`endif
  endtask

  task automatic test_async_reset();
    vec_t e, g;
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      tick(e, g);
      if (edge_k == 9) bus.locked = 1'b1;
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL async_pre edge=%0d got=%b exp=%b", edge_k, g, e); end
    end
    n_checks++;
    if (bus.state !== RELEASE) begin n_fail++; $display("FAIL in_release got=%0d exp=%0d", bus.state, RELEASE); end
    #4 rst_n = 1'b0;
    #1;
    g = {bus.pll_rst, bus.sys_rst_n, bus.sdram_rst_n, bus.ready, bus.retry_cnt};
    n_checks++;
    if (g !== {4'b1000, RW'(0)} || bus.state !== PLL_RST) begin
      n_fail++; $display("FAIL async_reset got=%b state=%0d exp=%b state=%0d", g, bus.state, {4'b1000, RW'(0)}, PLL_RST);
    end
    @(negedge refclk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(e, g);
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL async_post edge=%0d got=%b exp=%b", edge_k, g, e); end
    end
  endtask

  task automatic test_random();
    vec_t e, g;
    int hold;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      hold = $urandom_range(1, 12);
      for (int i = 0; i < 300; i++) begin
        tick(e, g);
        n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL random r=%0d edge=%0d got=%b exp=%b", r, edge_k, g, e); end
        hold--;
        if (hold <= 0) begin
          bus.locked = ~bus.locked;
          hold = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 40);
        end
      end
    end
  endtask

  initial begin
    bus.locked = 1'b0;
    test_reset();
    test_pll_release();
    test_lock_sequence();
    test_lock_loss();
    test_dropout();
    test_retry();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
